// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - word handshake bundle feeding the shift sequencer
interface shift_seq_if #(
    parameter int WIDTH = 7
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH:0]   s_data;
    logic             s_msb_first;

    modport master (output s_valid, output s_data, output s_msb_first, input s_ready);
    modport slave  (input s_valid, input s_data, input s_msb_first, output s_ready);
endinterface

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - serializer sequencer driving an external shift register; SHIFT_SEQ_PARITY_EN adds an even-parity bit
module shift_seq #(
    parameter int WIDTH = 7,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_if.slave       s,
    input  logic             abort,
    output logic             sh_en,
    output logic             sh_ld,
    output logic             sh_dir,
    output logic             sh_in,
    output logic [WIDTH:0]   sh_data,
    input  logic [WIDTH:0]   sh_q,
    output logic             txd,
    output logic             txd_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    localparam int              CW       = ($clog2(WIDTH + 1) > 0) ? $clog2(WIDTH + 1) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(WIDTH);
    localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_nxt;
    logic [7:0]      div_cnt, div_nxt;
    logic [WIDTH:0]  cap_data;
    logic            cap_msb;
    logic            aborted_q;
    logic            ready_c;
    logic            abort_hit;
    logic            unused_sh_q;

    // Only the end bits of the register are observed; the rest just travel through it.
    assign unused_sh_q = ^sh_q;

    assign sh_in   = 1'b0;
    assign sh_dir  = cap_msb;
    assign sh_data = cap_data;
    assign busy    = (state != IDLE);
    assign aborted = aborted_q;
    assign s.s_ready = ready_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            cap_data  <= '0;
            cap_msb   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            div_cnt   <= div_nxt;
            aborted_q <= abort_hit;
            if (state == IDLE && s.s_valid) begin
                cap_data <= s.s_data;
                cap_msb  <= s.s_msb_first;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        ready_c   = 1'b0;
        sh_en     = 1'b0;
        sh_ld     = 1'b0;
        txd       = 1'b0;
        txd_valid = 1'b0;
        done      = 1'b0;
        abort_hit = 1'b0;

        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (s.s_valid) state_nxt = LOAD;
            end
            LOAD: begin
                sh_ld     = 1'b1;
                sh_en     = 1'b1;
                bit_nxt   = '0;
                div_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                txd_valid = 1'b1;
                txd       = cap_msb ? sh_q[WIDTH] : sh_q[0];
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt < BIT_LAST) begin
                        sh_en   = 1'b1;
                        bit_nxt = bit_cnt + 1'b1;
                    end else begin
`ifdef SHIFT_SEQ_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = DONE;
`endif
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            PARITY: begin
                txd_valid = 1'b1;
                txd       = ^cap_data;
                if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Cancel wins over any shift or load scheduled for this cycle.
        if (abort && state != IDLE && state != DONE) begin
            abort_hit = 1'b1;
            state_nxt = IDLE;
            sh_en     = 1'b0;
            sh_ld     = 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed vector bench for shift_seq with a behavioural shift register
module tb_shift_seq;
    localparam int W = 7;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         abort;
    logic         sh_en, sh_ld, sh_dir, sh_in;
    logic [W:0]   sh_data;
    logic [W:0]   sh_q;
    logic         txd, txd_valid, busy, done, aborted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq_if #(.WIDTH(W)) bus ();

    shift_seq #(.WIDTH(W), .DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .abort     (abort),
        .sh_en     (sh_en),
        .sh_ld     (sh_ld),
        .sh_dir    (sh_dir),
        .sh_in     (sh_in),
        .sh_data   (sh_data),
        .sh_q      (sh_q),
        .txd       (txd),
        .txd_valid (txd_valid),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                sh_q <= '0;
        else if (sh_en && sh_ld) sh_q <= sh_data;
        else if (sh_en && sh_dir) sh_q <= {sh_q[W-1:0], sh_in};
        else if (sh_en)          sh_q <= {sh_in, sh_q[W:1]};
    end

    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] order;
        logic       par;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] data, input logic msb, input logic [7:0] order,
                             input logic par, input string tag, input bit hold,
                             input logic [7:0] nxt_data, input logic nxt_msb);
        logic [7:0] rx;
        bit stable, vld_ok, dir_ok, pos_ok;
        int pulses;
        rx = '0; stable = 1; vld_ok = 1; dir_ok = 1; pos_ok = 1; pulses = 0;
        bus.s_data = data;
        bus.s_msb_first = msb;
        bus.s_valid = 1'b1;
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
        step();
        check({tag, "_load"}, {27'd0, sh_ld, sh_en, busy, bus.s_ready, txd_valid}, 32'b11100);
        check({tag, "_sh_data"}, 32'(sh_data), 32'(data));
        if (hold) begin
            bus.s_data = nxt_data;
            bus.s_msb_first = nxt_msb;
        end else begin
            bus.s_valid = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < D; c++) begin
                step();
                if (txd_valid !== 1'b1 || busy !== 1'b1 || bus.s_ready !== 1'b0 || done !== 1'b0) vld_ok = 0;
                if (c == 0) rx[7-b] = txd;
                else if (txd !== rx[7-b]) stable = 0;
                if (sh_en === 1'b1) begin
                    pulses++;
                    if (sh_dir !== msb) dir_ok = 0;
                    if (!(c == D-1 && b < 7)) pos_ok = 0;
                end
            end
        end
        check({tag, "_bits"}, 32'(rx), 32'(order));
        check({tag, "_bit_hold"}, 32'(stable), 32'd1);
        check({tag, "_txd_valid"}, 32'(vld_ok), 32'd1);
        check({tag, "_pulses"}, 32'(pulses), 32'd7);
        check({tag, "_dir"}, 32'(dir_ok), 32'd1);
        check({tag, "_pulse_pos"}, 32'(pos_ok), 32'd1);
`ifdef SHIFT_SEQ_PARITY_EN
        stable = 1;
        for (int c = 0; c < D; c++) begin
            step();
            if (txd_valid !== 1'b1 || txd !== par || sh_en !== 1'b0 || done !== 1'b0) stable = 0;
        end
        check({tag, "_parity"}, 32'(stable), 32'd1);
`endif
        step();
        check({tag, "_done"}, {27'd0, done, busy, bus.s_ready, txd_valid, sh_en}, 32'b11000);
        step();
        check({tag, "_idle"}, {28'd0, done, busy, bus.s_ready, aborted}, 32'b0010);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 8'h01, 1'b1};
        vecs[3] = '{8'h01, 1'b0, 8'h80, 1'b1};
        vecs[4] = '{8'h12, 1'b0, 8'h48, 1'b0};
        vecs[5] = '{8'hF0, 1'b1, 8'hF0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 8'h07, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 8'hFF, 1'b0};

        rst = 1'b1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_msb_first = 1'b0;
        #2;
        check("reset_outs", {22'd0, bus.s_ready, busy, done, aborted, txd, txd_valid, sh_en, sh_ld, sh_dir, sh_in}, 32'd0);
        check("reset_sh_data", 32'(sh_data), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_reset_ready", {30'd0, bus.s_ready, busy}, 32'b10);

        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].data, vecs[i].msb, vecs[i].order, vecs[i].par,
                      $sformatf("v%0d", i), 1'b0, 8'h00, 1'b0);

        // back-to-back: second request held through the first frame
        run_frame(8'hA5, 1'b1, 8'hA5, 1'b0, "b2b_first", 1'b1, 8'h12, 1'b0);
        run_frame(8'h12, 1'b0, 8'h48, 1'b0, "b2b_second", 1'b0, 8'h00, 1'b0);

        // abort on a cycle that would otherwise carry a shift pulse
        bus.s_data = 8'hF0;
        bus.s_msb_first = 1'b1;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        repeat (8) step();
        check("abort_pre_pulse", 32'(sh_en), 32'd1);
        abort = 1'b1;
        #1;
        check("abort_no_pulse", {30'd0, sh_en, done}, 32'b00);
        step();
        abort = 1'b0;
        check("abort_pulse", {28'd0, aborted, busy, bus.s_ready, done}, 32'b1010);
        step();
        check("abort_clear", {29'd0, aborted, busy, done}, 32'b000);

        // abort while loading
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        abort = 1'b1;
        #1;
        check("abort_load_no_en", {30'd0, sh_en, sh_ld}, 32'b00);
        step();
        abort = 1'b0;
        check("abort_load_pulse", {30'd0, aborted, busy}, 32'b10);
        step();

        // abort in idle is ignored
        abort = 1'b1;
        step();
        check("abort_idle_ignored", {29'd0, aborted, busy, bus.s_ready}, 32'b001);
        abort = 1'b0;

        run_frame(vecs[0].data, vecs[0].msb, vecs[0].order, vecs[0].par, "after_abort", 1'b0, 8'h00, 1'b0);

        // reset mid-shift
        bus.s_data = 8'hA5;
        bus.s_msb_first = 1'b1;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("midrst_outs", {22'd0, bus.s_ready, busy, done, aborted, txd, txd_valid, sh_en, sh_ld, sh_dir, sh_in}, 32'd0);
        check("midrst_sh_data", 32'(sh_data), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("midrst_release", {28'd0, bus.s_ready, busy, done, aborted}, 32'b1000);
        run_frame(vecs[4].data, vecs[4].msb, vecs[4].order, vecs[4].par, "after_rst", 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 7, MSB index of the shifted word (word is WIDTH+1 bits).
REQ-002 SHALL have parameter DIV, default 4, clocks per serial bit (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port s_valid  input  1  request to send s_data.
REQ-006 SHALL have port s_ready  output  1  block can accept a word.
REQ-007 SHALL have port s_data  input  WIDTH+1  parallel word to serialize.
REQ-008 SHALL have port s_msb_first  input  1  1 = MSB first, 0 = LSB first; sampled with s_data.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current frame.
REQ-010 SHALL have ports sh_en, sh_ld, sh_dir, sh_in  output  1 each  controls to the external shift register; sh_dir 1 = shift left.
REQ-011 SHALL have port sh_data  output  WIDTH+1  parallel load value for the shift register.
REQ-012 SHALL have port sh_q  input  WIDTH+1  current shift register contents.
REQ-013 SHALL have ports txd, txd_valid  output  1 each  serial bit and its qualifier.
REQ-014 SHALL have ports busy, done, aborted  output  1 each  frame active, one-cycle completion pulse, one-cycle abort pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, PARITY, DONE.
REQ-016 IDLE: s_ready=1; on s_valid&s_ready SHALL capture s_data and s_msb_first and go to LOAD.
REQ-017 LOAD (1 cycle): sh_ld=1, sh_en=1, sh_data=captured word; bit counter and divider counter cleared; next SHIFT.
REQ-018 SHIFT: txd_valid=1; txd=sh_q[WIDTH] if MSB first else sh_q[0]; divider counts 0..DIV-1.
REQ-019 SHIFT: at divider==DIV-1 and bit counter<WIDTH SHALL pulse sh_en=1 for one cycle with sh_dir=captured msb_first, increment bit counter, clear divider.
REQ-020 SHIFT: at divider==DIV-1 and bit counter==WIDTH SHALL go to PARITY (macro defined) or DONE (not defined); no final shift pulse.
REQ-021 Each data bit SHALL be presented on txd for exactly DIV cycles; frame of WIDTH+1 bits, first txd_valid cycle is 2 cycles after the accepting edge.
REQ-022 DONE (1 cycle): done=1, s_ready=0; next IDLE.
REQ-023 sh_in SHALL be constant 0; sh_data SHALL hold the captured word at all times after capture.
REQ-024 busy SHALL be 1 in every state except IDLE; s_ready SHALL be 0 whenever busy=1; s_valid while busy is ignored.
REQ-025 abort in LOAD, SHIFT or PARITY SHALL return to IDLE next cycle with aborted=1 for one cycle, done=0, no sh_en pulse in that cycle; abort in IDLE or DONE SHALL be ignored.
REQ-026 sh_en, sh_ld, txd_valid, done, aborted SHALL be 0 in all states not listed as driving them.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counters 0, captured word 0, captured direction 0.
REQ-028 During reset: s_ready=0, busy=0, done=0, aborted=0, txd=0, txd_valid=0, sh_en=0, sh_ld=0, sh_dir=0, sh_in=0, sh_data=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no done or aborted pulse; s_ready=1 from first clock after release.

Configuration
REQ-030 Macro SHIFT_SEQ_PARITY_EN defined: PARITY state present, txd = XOR of captured word (even parity), txd_valid=1 for DIV cycles, then DONE; abort honoured as in REQ-025.
REQ-031 Macro not defined: PARITY state and logic absent; SHIFT goes directly to DONE; frame is WIDTH+1 bits.

Verification
REQ-032 WIDTH=7, DIV=4, word 0xA5, MSB first, no macro -> txd 1,0,1,0,0,1,0,1 each 4 cycles, 7 sh_en shift pulses with sh_dir=1, done 1 cycle after last bit.
REQ-033 Same word, LSB first -> txd 1,0,1,0,0,1,0,1 reversed order (LSB 1 first), sh_dir=0.
REQ-034 Macro defined, word 0x07 -> 8 data bits then parity bit 1 for 4 cycles, then done.
REQ-035 abort asserted 10 cycles into a frame -> aborted pulse next cycle, done never asserted, s_ready=1 following cycle.
REQ-036 Second s_valid held during frame -> ignored; accepted in first IDLE cycle after done (back-to-back frames, one idle cycle gap).
REQ-037 rst pulsed mid-SHIFT -> all outputs at REQ-028 values asynchronously; new frame after release completes normally.
